// File: rtl/buffered_fifo_ctrl.sv
// Show-ahead FIFO controller for a buffered_ram with 2-cycle read latency.
// A 3-entry skid buffer absorbs the RAM latency so the stream runs at full rate.
module buffered_fifo_ctrl #(
   parameter int p_addresswidth = 4,
   parameter int p_datawidth    = 16
) (
   input  logic                      inclk,
   input  logic                      inrst,
   input  logic                      in_wrreq,
   input  logic [p_datawidth-1:0]    in_wrdata,
   output logic                      out_full,
   input  logic                      in_rdack,
   output logic                      out_rdvalid,
   output logic [p_datawidth-1:0]    out_rddata,
   output logic [p_addresswidth+1:0] out_usedw,
   output logic                      out_overflow,
   output logic                      out_underflow,
   output logic                      out_ram_wren,
   output logic [p_addresswidth-1:0] out_ram_wraddress,
   output logic [p_datawidth-1:0]    out_ram_wrdata,
   output logic [p_addresswidth-1:0] out_ram_rdaddress,
   input  logic [p_datawidth-1:0]    in_ram_rddata
);

   localparam int AW = p_addresswidth;
   localparam int DW = p_datawidth;
   localparam int UW = p_addresswidth + 2;
   localparam logic [AW:0] RAM_FULL = (AW+1)'(2**AW);

   logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]           ram_used_q, ram_used_d;
   logic [1:0]            vld_pipe_q, vld_pipe_d;
   logic [2:0][DW-1:0]    skid_q, skid_d;
   logic [1:0]            skid_cnt_q, skid_cnt_d;
   logic [UW-1:0]         usedw_q, usedw_d;
   logic                  ovf_q, udf_q;
   logic                  push, pop, issue, capture;
   logic [2:0]            pending;
   logic [1:0]            wr_idx;

   assign out_full    = (ram_used_q == RAM_FULL);
   assign out_rdvalid = (skid_cnt_q != 2'd0);
   assign push        = in_wrreq & ~out_full;
   assign pop         = in_rdack & out_rdvalid;
   assign capture     = vld_pipe_q[1];

   // Words already committed downstream of the RAM after this cycle's pop.
   assign pending = 3'(vld_pipe_q[0]) + 3'(vld_pipe_q[1]) + 3'(skid_cnt_q) - 3'(pop);
   assign issue   = (ram_used_q != '0) & (pending < 3'd3);
   assign wr_idx  = skid_cnt_q - 2'(pop);

   assign out_ram_wren      = push;
   assign out_ram_wraddress = wptr_q;
   assign out_ram_wrdata    = in_wrdata;
   assign out_ram_rdaddress = rptr_q;
   assign out_rddata        = skid_q[0];
   assign out_usedw         = usedw_q;
   assign out_overflow      = ovf_q;
   assign out_underflow     = udf_q;

   always_comb begin
      wptr_d     = wptr_q + AW'(push);
      rptr_d     = rptr_q + AW'(issue);
      ram_used_d = ram_used_q + (AW+1)'(push) - (AW+1)'(issue);
      vld_pipe_d = {vld_pipe_q[0], issue};
      skid_cnt_d = skid_cnt_q + 2'(capture) - 2'(pop);
      skid_d     = skid_q;
      if (pop) begin
         skid_d[0] = skid_q[1];
         skid_d[1] = skid_q[2];
      end
      // Capture lands behind whatever survives this cycle's pop.
      for (int i = 0; i < 3; i++)
         if (capture && wr_idx == 2'(i)) skid_d[i] = in_ram_rddata;
      usedw_d = UW'(ram_used_d) + UW'(vld_pipe_d[0]) + UW'(vld_pipe_d[1]) + UW'(skid_cnt_d);
   end

   always_ff @(posedge inclk) begin
      if (inrst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         ram_used_q <= '0;
         vld_pipe_q <= '0;
         skid_q     <= '0;
         skid_cnt_q <= '0;
         usedw_q    <= '0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         ram_used_q <= ram_used_d;
         vld_pipe_q <= vld_pipe_d;
         skid_q     <= skid_d;
         skid_cnt_q <= skid_cnt_d;
         usedw_q    <= usedw_d;
         ovf_q      <= ovf_q | (in_wrreq & out_full);
         udf_q      <= udf_q | (in_rdack & ~out_rdvalid);
      end
   end

endmodule

// File: tb/tb_buffered_fifo_ctrl.sv
// Directed bench for buffered_fifo_ctrl with a 2-cycle-latency RAM model attached.
module tb_buffered_fifo_ctrl;

   localparam int AW = 4;
   localparam int DW = 16;

   logic          inclk = 1'b0;
   logic          inrst;
   logic          in_wrreq;
   logic [DW-1:0] in_wrdata;
   logic          out_full;
   logic          in_rdack;
   logic          out_rdvalid;
   logic [DW-1:0] out_rddata;
   logic [AW+1:0] out_usedw;
   logic          out_overflow, out_underflow;
   logic          out_ram_wren;
   logic [AW-1:0] out_ram_wraddress, out_ram_rdaddress;
   logic [DW-1:0] out_ram_wrdata, in_ram_rddata;

   int vectors = 0;
   int miscompares = 0;

   always #5 inclk = ~inclk;

   buffered_fifo_ctrl #(.p_addresswidth(AW), .p_datawidth(DW)) dut (
      .inclk(inclk), .inrst(inrst),
      .in_wrreq(in_wrreq), .in_wrdata(in_wrdata), .out_full(out_full),
      .in_rdack(in_rdack), .out_rdvalid(out_rdvalid), .out_rddata(out_rddata),
      .out_usedw(out_usedw), .out_overflow(out_overflow), .out_underflow(out_underflow),
      .out_ram_wren(out_ram_wren), .out_ram_wraddress(out_ram_wraddress),
      .out_ram_wrdata(out_ram_wrdata), .out_ram_rdaddress(out_ram_rdaddress),
      .in_ram_rddata(in_ram_rddata)
   );

   // buffered_ram: registered read address and registered output.
   logic [DW-1:0] mem [2**AW];
   logic [AW-1:0] ram_rdaddr_q;
   always @(posedge inclk) begin
      if (out_ram_wren) mem[out_ram_wraddress] <= out_ram_wrdata;
      ram_rdaddr_q  <= out_ram_rdaddress;
      in_ram_rddata <= mem[ram_rdaddr_q];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge inclk);
      #2;
   endtask

   task automatic drive(input logic wr, input logic [DW-1:0] d, input logic ack);
      in_wrreq  = wr;
      in_wrdata = d;
      in_rdack  = ack;
      #1;
   endtask

   task automatic do_reset();
      inrst = 1'b1;
      drive(1'b0, '0, 1'b0);
      next_cyc();
      inrst = 1'b0;
   endtask

   initial begin
      inrst = 1'b1;
      in_wrreq = 1'b0; in_wrdata = '0; in_rdack = 1'b0;
      for (int i = 0; i < 2**AW; i++) mem[i] = '0;
      ram_rdaddr_q = '0;
      in_ram_rddata = '0;

      // Reset state
      do_reset();
      drive(1'b0, '0, 1'b0);
      chk("rst_usedw", 32'(out_usedw), 0);
      chk("rst_rdvalid", 32'(out_rdvalid), 0);
      chk("rst_full", 32'(out_full), 0);
      chk("rst_wren", 32'(out_ram_wren), 0);
      chk("rst_rddata", 32'(out_rddata), 0);
      chk("rst_flags", {30'b0, out_overflow, out_underflow}, 0);

      // Single word
      drive(1'b1, 16'hA5A5, 1'b0);
      chk("sw_wren", 32'(out_ram_wren), 1);
      chk("sw_wraddr", 32'(out_ram_wraddress), 0);
      chk("sw_wrdata", 32'(out_ram_wrdata), 32'hA5A5);
      next_cyc(); drive(1'b0, '0, 1'b0);
      chk("sw_usedw_c1", 32'(out_usedw), 1);
      chk("sw_rdaddr_c1", 32'(out_ram_rdaddress), 0);
      next_cyc(); drive(1'b0, '0, 1'b0);
      chk("sw_rdaddr_c2", 32'(out_ram_rdaddress), 1);
      next_cyc(); drive(1'b0, '0, 1'b0);
      chk("sw_rdvalid_c3", 32'(out_rdvalid), 0);
      next_cyc(); drive(1'b0, '0, 1'b1);
      chk("sw_rdvalid_c4", 32'(out_rdvalid), 1);
      chk("sw_rddata_c4", 32'(out_rddata), 32'hA5A5);
      chk("sw_usedw_c4", 32'(out_usedw), 1);
      next_cyc(); drive(1'b0, '0, 1'b0);
      chk("sw_rdvalid_c5", 32'(out_rdvalid), 0);
      chk("sw_usedw_c5", 32'(out_usedw), 0);

      // Fill: 16 RAM words + 3 in the prefetch path
      for (int i = 0; i < 31; i++) begin
         drive(1'b1, DW'(i), 1'b0);
         chk($sformatf("fill_wren_%0d", i), 32'(out_ram_wren), (i < 19) ? 1 : 0);
         chk($sformatf("fill_full_%0d", i), 32'(out_full), (i >= 19) ? 1 : 0);
         next_cyc();
      end
      drive(1'b0, '0, 1'b0);
      chk("fill_usedw", 32'(out_usedw), 19);
      chk("fill_overflow", 32'(out_overflow), 1);
      chk("fill_underflow", 32'(out_underflow), 0);
      chk("fill_head", 32'(out_rddata), 0);

      // Drain without gaps
      for (int k = 0; k < 19; k++) begin
         drive(1'b0, '0, 1'b1);
         chk($sformatf("drain_valid_%0d", k), 32'(out_rdvalid), 1);
         chk($sformatf("drain_data_%0d", k), 32'(out_rddata), k);
         next_cyc();
      end
      drive(1'b0, '0, 1'b0);
      chk("drain_rdvalid", 32'(out_rdvalid), 0);
      chk("drain_usedw", 32'(out_usedw), 0);
      chk("drain_full", 32'(out_full), 0);

      // Streaming 1 push + 1 pop per cycle
      do_reset();
      for (int c = 0; c < 105; c++) begin
         drive(c < 100, DW'(c), (c >= 4 && c < 104));
         chk($sformatf("stream_valid_%0d", c), 32'(out_rdvalid), (c >= 4 && c < 104) ? 1 : 0);
         if (c >= 4 && c < 104)
            chk($sformatf("stream_data_%0d", c), 32'(out_rddata), c - 4);
         chk($sformatf("stream_usedw_le4_%0d", c), 32'(out_usedw <= 4), 1);
         next_cyc();
      end
      drive(1'b0, '0, 1'b0);
      chk("stream_usedw_end", 32'(out_usedw), 0);
      chk("stream_flags", {30'b0, out_overflow, out_underflow}, 0);

      // Fill to 10 / drain to 0 across pointer wrap
      for (int r = 0; r < 50; r++) begin
         for (int i = 0; i < 10; i++) begin
            drive(1'b1, DW'(r * 10 + i), 1'b0);
            chk($sformatf("wrap_push_usedw_r%0d_%0d", r, i), 32'(out_usedw), i);
            next_cyc();
         end
         for (int s = 0; s < 2; s++) begin
            drive(1'b0, '0, 1'b0);
            chk($sformatf("wrap_idle_usedw_r%0d", r), 32'(out_usedw), 10);
            next_cyc();
         end
         for (int k = 0; k < 10; k++) begin
            drive(1'b0, '0, 1'b1);
            chk($sformatf("wrap_valid_r%0d_%0d", r, k), 32'(out_rdvalid), 1);
            chk($sformatf("wrap_data_r%0d_%0d", r, k), 32'(out_rddata), (r * 10 + k) & 16'hFFFF);
            chk($sformatf("wrap_pop_usedw_r%0d_%0d", r, k), 32'(out_usedw), 10 - k);
            next_cyc();
         end
         drive(1'b0, '0, 1'b0);
         chk($sformatf("wrap_empty_r%0d", r), {31'b0, out_rdvalid}, 0);
         chk($sformatf("wrap_end_usedw_r%0d", r), 32'(out_usedw), 0);
      end
      chk("wrap_flags", {30'b0, out_overflow, out_underflow}, 0);

      // Underflow on empty
      drive(1'b0, '0, 1'b1);
      next_cyc(); drive(1'b0, '0, 1'b0);
      chk("udf_flag", 32'(out_underflow), 1);
      chk("udf_usedw", 32'(out_usedw), 0);
      chk("udf_rdvalid", 32'(out_rdvalid), 0);
      chk("udf_overflow", 32'(out_overflow), 0);

      // Reset mid-flight
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, DW'(16'h0100 + i), 1'b0);
         next_cyc();
      end
      do_reset();
      drive(1'b0, '0, 1'b0);
      chk("mrst_usedw", 32'(out_usedw), 0);
      chk("mrst_rdvalid", 32'(out_rdvalid), 0);
      chk("mrst_full", 32'(out_full), 0);
      chk("mrst_wren", 32'(out_ram_wren), 0);
      chk("mrst_rddata", 32'(out_rddata), 0);
      chk("mrst_flags", {30'b0, out_overflow, out_underflow}, 0);
      chk("mrst_rdaddr", 32'(out_ram_rdaddress), 0);

      drive(1'b1, 16'h1234, 1'b0);
      chk("post_wraddr", 32'(out_ram_wraddress), 0);
      for (int c = 1; c < 4; c++) begin
         next_cyc(); drive(1'b0, '0, 1'b0);
         chk($sformatf("post_rdvalid_c%0d", c), 32'(out_rdvalid), 0);
      end
      next_cyc(); drive(1'b0, '0, 1'b0);
      chk("post_rdvalid_c4", 32'(out_rdvalid), 1);
      chk("post_rddata_c4", 32'(out_rddata), 32'h1234);
      chk("post_usedw_c4", 32'(out_usedw), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
